// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: FSM state encodings and shared constants for the hazard controller
package pipe_hazard_ctrl_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// pipe_hazard_ctrl_hazard_detect: load-use compare of ID sources (rs1/rs2 + read enables) against an EX load rd -> lu
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_re_i,
  input  logic       id_rs2_re_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_rd_we_i,
  input  logic       ex_is_load_i,
  output logic       lu
);
  assign lu = ex_valid_i & ex_is_load_i & ex_rd_we_i & (ex_rd_addr_i != ZERO_REG) & id_valid_i &
              ((id_rs1_re_i & (id_rs1_addr_i == ex_rd_addr_i)) | (id_rs2_re_i & (id_rs2_addr_i == ex_rd_addr_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble control for PC, IF/ID, ID/EX (load-use, EX redirect, multi-cycle EX) with timeout error pulse and stall counter
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN        = pipe_hazard_ctrl_pkg::XLEN,
  parameter int FLUSH_EXTRA = 1,
  parameter int MC_TIMEOUT  = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_re_i,
  input  logic             id_rs2_re_i,
  input  logic             ex_valid_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_we_i,
  input  logic             ex_is_load_i,
  input  logic             ex_mc_start_i,
  input  logic             ex_mc_done_i,
  input  logic             ex_br_taken_i,
  input  logic [XLEN-1:0]  ex_br_target_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_bubble_o,
  output logic             pc_redirect_o,
  output logic [XLEN-1:0]  pc_target_o,
  output logic             mc_err_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int TW = $clog2(MC_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(MC_TIMEOUT);
  state_t state, nxt;
  logic [TW-1:0] to_cnt;
  logic [2:0] flush_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic mc_err, lu, run, br, mcs, lus, mws, fl, tmo;
  pipe_hazard_ctrl_hazard_detect u_hd (
    .id_valid_i    (id_valid_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_re_i   (id_rs1_re_i),
    .id_rs2_re_i   (id_rs2_re_i),
    .ex_valid_i    (ex_valid_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_rd_we_i    (ex_rd_we_i),
    .ex_is_load_i  (ex_is_load_i),
    .lu            (lu)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_RUN;
      to_cnt    <= '0;
      flush_cnt <= '0;
      mc_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= nxt;
      to_cnt    <= (state == ST_MC_WAIT) ? to_cnt + TW'(1) : TW'(1);
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt - 3'd1 : 3'(FLUSH_EXTRA);
      mc_err    <= tmo;
      if (pc_stall_o && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
  always_comb begin
    nxt = state;
    if (state == ST_RUN)
      nxt = ex_br_taken_i ? ((FLUSH_EXTRA == 0) ? ST_RUN : ST_FLUSH)
          : (ex_mc_start_i & ~ex_mc_done_i) ? ST_MC_WAIT : ST_RUN;
    else if (state == ST_MC_WAIT)
      nxt = (ex_mc_done_i | (to_cnt == TO_MAX)) ? ST_RUN : ST_MC_WAIT;
    else if (state == ST_FLUSH)
      nxt = (flush_cnt == 3'd1) ? ST_RUN : ST_FLUSH;
    else
      nxt = ST_RUN;
  end
  // RUN priority is branch > multi-cycle start > load-use; a start with done already set suppresses load-use too
  always_comb begin
    run           = ~rst_i & (state == ST_RUN);
    br            = run & ex_br_taken_i;
    mcs           = run & ~ex_br_taken_i & ex_mc_start_i & ~ex_mc_done_i;
    lus           = run & ~ex_br_taken_i & ~ex_mc_start_i & lu;
    tmo           = ~rst_i & (state == ST_MC_WAIT) & ~ex_mc_done_i & (to_cnt == TO_MAX);
    mws           = ~rst_i & (state == ST_MC_WAIT) & ~ex_mc_done_i & (to_cnt != TO_MAX);
    fl            = ~rst_i & (state == ST_FLUSH);
    pc_stall_o    = mcs | lus | mws;
    ifid_stall_o  = mcs | lus | mws;
    idex_stall_o  = mcs | mws;
    ifid_flush_o  = br | fl;
    idex_bubble_o = br | lus | fl;
    pc_redirect_o = br;
    pc_target_o   = br ? ex_br_target_i : '0;
    mc_err_o      = ~rst_i & mc_err;
    state_o       = rst_i ? 2'd0 : state;
    stall_cnt_o   = rst_i ? '0 : stall_cnt;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed-vector self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk_i = 1'b0, rst_i;
  logic id_valid_i, id_rs1_re_i, id_rs2_re_i, ex_valid_i, ex_rd_we_i, ex_is_load_i;
  logic ex_mc_start_i, ex_mc_done_i, ex_br_taken_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic [31:0] ex_br_target_i, pc_target_o, stall_cnt_o;
  logic pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_bubble_o, pc_redirect_o, mc_err_o;
  logic [1:0] state_o;
  logic [5:0] ctl;
  int vectors = 0, miss = 0;
  localparam logic [5:0] NONE = 6'b000000, LUS = 6'b110010, MCS = 6'b110100, BR = 6'b001011, FL = 6'b001010;
  always #5 clk_i = ~clk_i;
  assign ctl = {pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_bubble_o, pc_redirect_o};
  pipe_hazard_ctrl #(.XLEN(32), .FLUSH_EXTRA(1), .MC_TIMEOUT(8), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
    .ex_valid_i(ex_valid_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_we_i(ex_rd_we_i),
    .ex_is_load_i(ex_is_load_i), .ex_mc_start_i(ex_mc_start_i), .ex_mc_done_i(ex_mc_done_i),
    .ex_br_taken_i(ex_br_taken_i), .ex_br_target_i(ex_br_target_i), .pc_stall_o(pc_stall_o),
    .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o), .idex_stall_o(idex_stall_o),
    .idex_bubble_o(idex_bubble_o), .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o),
    .mc_err_o(mc_err_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic clr;
    {id_valid_i, id_rs1_re_i, id_rs2_re_i, ex_valid_i, ex_rd_we_i, ex_is_load_i} = '0;
    {ex_mc_start_i, ex_mc_done_i, ex_br_taken_i} = '0;
    {id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i} = '0;
    ex_br_target_i = '0;
  endtask
  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic re1, input logic [4:0] rs2, input logic re2);
    {ex_valid_i, ex_is_load_i, ex_rd_we_i, id_valid_i} = 4'b1111;
    ex_rd_addr_i = rd;
    id_rs1_addr_i = rs1;
    id_rs1_re_i = re1;
    id_rs2_addr_i = rs2;
    id_rs2_re_i = re2;
  endtask
  initial begin
    clr();
    rst_i = 1'b1;
    tick();
    ex_br_taken_i = 1'b1;
    ex_br_target_i = 32'h100;
    #2;
    chk("rst_ctl", 32'(ctl), 32'(NONE));
    chk("rst_target", pc_target_o, 32'h0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_cnt", stall_cnt_o, 0);
    chk("rst_err", 32'(mc_err_o), 0);
    tick();
    clr();
    rst_i = 1'b0;
    load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #2;
    chk("lu_rs1_ctl", 32'(ctl), 32'(LUS));
    tick();
    ex_valid_i = 1'b0;
    #2;
    chk("lu_after_ctl", 32'(ctl), 32'(NONE));
    chk("lu_after_cnt", stall_cnt_o, 1);
    chk("lu_after_state", 32'(state_o), 0);
    load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    #2;
    chk("lu_rd0_ctl", 32'(ctl), 32'(NONE));
    load_use(5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
    #2;
    chk("lu_re0_ctl", 32'(ctl), 32'(NONE));
    load_use(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
    #2;
    chk("lu_rs2_ctl", 32'(ctl), 32'(LUS));
    tick();
    clr();
    #2;
    chk("lu_rs2_cnt", stall_cnt_o, 2);
    ex_br_taken_i = 1'b1;
    ex_br_target_i = 32'h0000_0100;
    #2;
    chk("br_c0_ctl", 32'(ctl), 32'(BR));
    chk("br_c0_target", pc_target_o, 32'h100);
    tick();
    clr();
    #2;
    chk("br_c1_state", 32'(state_o), 2);
    chk("br_c1_ctl", 32'(ctl), 32'(FL));
    chk("br_c1_target", pc_target_o, 32'h0);
    tick();
    chk("br_c2_state", 32'(state_o), 0);
    chk("br_c2_ctl", 32'(ctl), 32'(NONE));
    load_use(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    ex_br_taken_i = 1'b1;
    ex_br_target_i = 32'h0000_0200;
    ex_mc_start_i = 1'b1;
    #2;
    chk("prio_ctl", 32'(ctl), 32'(BR));
    chk("prio_target", pc_target_o, 32'h200);
    tick();
    clr();
    #2;
    chk("prio_state", 32'(state_o), 2);
    chk("prio_cnt", stall_cnt_o, 2);
    tick();
    ex_mc_start_i = 1'b1;
    #2;
    chk("mc_c0_ctl", 32'(ctl), 32'(MCS));
    tick();
    ex_mc_start_i = 1'b0;
    #2;
    chk("mc_c1_state", 32'(state_o), 1);
    chk("mc_c1_ctl", 32'(ctl), 32'(MCS));
    tick();
    load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    ex_br_taken_i = 1'b1;
    ex_mc_start_i = 1'b1;
    #2;
    chk("mc_c2_ignore_ctl", 32'(ctl), 32'(MCS));
    tick();
    clr();
    #2;
    chk("mc_c3_ctl", 32'(ctl), 32'(MCS));
    tick();
    ex_mc_done_i = 1'b1;
    #2;
    chk("mc_c4_ctl", 32'(ctl), 32'(NONE));
    chk("mc_c4_state", 32'(state_o), 1);
    tick();
    ex_mc_done_i = 1'b0;
    #2;
    chk("mc_c5_state", 32'(state_o), 0);
    chk("mc_c5_cnt", stall_cnt_o, 6);
    load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    ex_mc_start_i = 1'b1;
    ex_mc_done_i = 1'b1;
    #2;
    chk("mc0_ctl", 32'(ctl), 32'(NONE));
    tick();
    clr();
    #2;
    chk("mc0_state", 32'(state_o), 0);
    chk("mc0_cnt", stall_cnt_o, 6);
    ex_mc_start_i = 1'b1;
    #2;
    chk("to_c0_ctl", 32'(ctl), 32'(MCS));
    tick();
    ex_mc_start_i = 1'b0;
    for (int i = 1; i < 8; i++) begin
      #2;
      chk($sformatf("to_c%0d_ctl", i), 32'(ctl), 32'(MCS));
      tick();
    end
    #2;
    chk("to_c8_ctl", 32'(ctl), 32'(NONE));
    chk("to_c8_state", 32'(state_o), 1);
    chk("to_c8_err", 32'(mc_err_o), 0);
    tick();
    chk("to_c9_err", 32'(mc_err_o), 1);
    chk("to_c9_state", 32'(state_o), 0);
    chk("to_c9_cnt", stall_cnt_o, 14);
    tick();
    chk("to_c10_err", 32'(mc_err_o), 0);
    ex_mc_start_i = 1'b1;
    tick();
    ex_mc_start_i = 1'b0;
    #2;
    chk("rstmc_pre_state", 32'(state_o), 1);
    rst_i = 1'b1;
    #1;
    chk("rstmc_during_ctl", 32'(ctl), 32'(NONE));
    chk("rstmc_during_cnt", stall_cnt_o, 0);
    tick();
    rst_i = 1'b0;
    #2;
    chk("rstmc_state", 32'(state_o), 0);
    chk("rstmc_ctl", 32'(ctl), 32'(NONE));
    chk("rstmc_cnt", stall_cnt_o, 0);
    chk("rstmc_err", 32'(mc_err_o), 0);
    ex_br_taken_i = 1'b1;
    ex_br_target_i = 32'h300;
    tick();
    clr();
    #2;
    chk("rstfl_pre_state", 32'(state_o), 2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #2;
    chk("rstfl_state", 32'(state_o), 0);
    chk("rstfl_ctl", 32'(ctl), 32'(NONE));
    tick();
    chk("rstfl_err", 32'(mc_err_o), 0);
    chk("rstfl_state2", 32'(state_o), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline controller for the IF/ID/EX datapath around the decode stage. It generates stall, flush and bubble controls for the PC, IF/ID and ID/EX registers. It covers three cases: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle EX operations (mul/div). It sits beside decode and sees ID source addresses and the EX destination and status. It also keeps a saturating stall-cycle counter for performance.

Parameters:
XLEN, 32, datapath width (matches `XLEN)
FLUSH_EXTRA, 1, extra cycles IF/ID is flushed after a redirect (fetch latency), 0..7
MC_TIMEOUT, 64, max cycles in MC_WAIT before forced release and error pulse, >=2
CNT_W, 32, width of stall_cnt_o

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
id_valid_i  in  1  ID holds a valid instruction
id_rs1_addr_i  in  5  ID rs1 address
id_rs2_addr_i  in  5  ID rs2 address
id_rs1_re_i  in  1  ID instruction reads rs1
id_rs2_re_i  in  1  ID instruction reads rs2
ex_valid_i  in  1  EX holds a valid instruction
ex_rd_addr_i  in  5  EX destination
ex_rd_we_i  in  1  EX writes rd
ex_is_load_i  in  1  EX instruction is a load
ex_mc_start_i  in  1  multi-cycle op entered EX this cycle
ex_mc_done_i  in  1  multi-cycle unit result ready
ex_br_taken_i  in  1  EX resolved taken branch/jump
ex_br_target_i  in  XLEN  redirect target
pc_stall_o  out  1  hold PC
ifid_stall_o  out  1  hold IF/ID
ifid_flush_o  out  1  clear IF/ID to NOP
idex_stall_o  out  1  hold ID/EX
idex_bubble_o  out  1  load NOP into ID/EX
pc_redirect_o  out  1  load PC with pc_target_o
pc_target_o  out  XLEN  redirect address
mc_err_o  out  1  one-cycle pulse on MC timeout
state_o  out  2  FSM state (RUN=0, MC_WAIT=1, FLUSH=2)
stall_cnt_o  out  CNT_W  saturating count of cycles with pc_stall_o=1

Behaviour:
- Control outputs are combinational from the registered state and the current inputs. state, counters, mc_err_o and stall_cnt_o are registered.
- While rst_i=1, all outputs are forced to 0, including pc_target_o. On the reset edge: state<=RUN, counters<=0, stall_cnt_o<=0. Reset mid-MC_WAIT or mid-FLUSH abandons the state with no pulse.
- Load-use hazard (lu) = ex_valid_i & ex_is_load_i & ex_rd_we_i & (ex_rd_addr_i!=0) & id_valid_i & ((id_rs1_re_i & rs1==rd) | (id_rs2_re_i & rs2==rd)).
- RUN, priority branch > mc > lu:
  - ex_br_taken_i: pc_redirect_o=1, pc_target_o=ex_br_target_i, ifid_flush_o=1, idex_bubble_o=1. Next state is FLUSH with flush_cnt=FLUSH_EXTRA; if FLUSH_EXTRA=0, stay RUN.
  - else ex_mc_start_i & !ex_mc_done_i: pc_stall_o=ifid_stall_o=idex_stall_o=1. Next state MC_WAIT, to_cnt=1.
  - else ex_mc_start_i & ex_mc_done_i: zero-latency op, no stall, stay RUN.
  - else lu: pc_stall_o=ifid_stall_o=1, idex_bubble_o=1 for that cycle only. The bubble clears the hazard the next cycle, so lu adds exactly 1 stall cycle.
- MC_WAIT:
  - ex_mc_done_i=0: pc_stall_o=ifid_stall_o=idex_stall_o=1, to_cnt++.
  - ex_mc_done_i=1: all stalls deasserted this cycle, next RUN.
  - to_cnt==MC_TIMEOUT without done: stalls deasserted, mc_err_o=1 next cycle for 1 cycle, next RUN.
  - Branch, lu and ex_mc_start_i are ignored in MC_WAIT.
- FLUSH:
  - ifid_flush_o=1 and idex_bubble_o=1; all other control outputs 0; flush_cnt--.
  - Next state RUN when flush_cnt==1.
  - EX inputs are ignored, because EX holds a bubble.
- stall_cnt_o increments on every cycle with pc_stall_o=1 and saturates at all-ones.
- idex_stall_o and idex_bubble_o are never both 1. ifid_stall_o and ifid_flush_o are never both 1.

Decomposition:
- Shared package / defines.v additions: state encodings ST_RUN, ST_MC_WAIT, ST_FLUSH, a 5-bit ZERO_REG constant, and the `XLEN reuse.
- One natural sub-module: hazard_detect, the combinational lu compare. The FSM, counters and output decode stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: EX load rd=5, ID rs1=5 re=1 -> one cycle of pc_stall=ifid_stall=idex_bubble=1, stall_cnt_o=1. With rd=0, or rs1_re=0 -> no stall.
- Branch: ex_br_taken_i=1, target=0x0000_0100, FLUSH_EXTRA=1 -> cycle 0 pc_redirect=1, pc_target=0x100, flush and bubble. Cycle 1 state=FLUSH, flush and bubble. Cycle 2 RUN.
- Priority: taken branch, mc_start and lu all in the same cycle -> only redirect/flush, state=FLUSH, stall_cnt unchanged.
- Multi-cycle: mc_start at cycle 0, done at cycle 4 -> stalls high for cycles 0..3, low at cycle 4, RUN at cycle 5, stall_cnt=4. mc_start & done together -> no stall.
- Timeout: MC_TIMEOUT=8, done never asserted -> stalls for 8 cycles, release, then a single-cycle mc_err_o pulse, state_o=0.
- Reset: rst_i asserted in MC_WAIT and in FLUSH -> next cycle all outputs 0, state_o=0, stall_cnt_o=0, no mc_err_o.
